// File: rtl/l1d_cache_control.sv
// Control FSM for the 2-way set-associative write-back L1 data cache.
// Drives the array strobes and pmem handshakes, and counts hits and misses.
module l1d_cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [1:0]           hit_i,
    input  logic [1:0]           dirty_i,
    input  logic [1:0]           valid_i,
    input  logic                 lru_i,
    input  logic                 pmem_resp_i,
    output logic                 mem_resp_o,
    output logic [1:0]           load_data_o,
    output logic [1:0]           load_tag_o,
    output logic [1:0]           load_valid_o,
    output logic [1:0]           load_dirty_o,
    output logic                 dirty_in_o,
    output logic                 load_lru_o,
    output logic                 lru_in_o,
    output logic                 datain_sel_o,
    output logic                 pmem_addr_sel_o,
    output logic                 way_sel_o,
    output logic                 pmem_read_o,
    output logic                 pmem_write_o,
    output logic [CNT_WIDTH-1:0] hit_count_o,
    output logic [CNT_WIDTH-1:0] miss_count_o
);

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   victim_q, victim_d;
    logic                   missed_q, missed_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

    logic                   req_s;
    logic                   is_write_s;
    logic                   hit_any_s;
    logic                   hit_way_s;
    logic                   victim_dirty_s;
    logic [1:0]             hit_mask_s;
    logic [1:0]             victim_mask_s;

    function automatic logic [1:0] way_mask(input logic way);
        way_mask = way ? 2'b10 : 2'b01;
    endfunction

    // Request decode; a simultaneous read+write counts as a write and hit==11 resolves to way0.
    always_comb begin
        req_s          = mem_read_i | mem_write_i;
        is_write_s     = mem_write_i;
        hit_any_s      = |hit_i;
        hit_way_s      = ~hit_i[0] & hit_i[1];
        victim_dirty_s = valid_i[lru_i] & dirty_i[lru_i];
        hit_mask_s     = way_mask(hit_way_s);
        victim_mask_s  = way_mask(victim_q);
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COMPARE: begin
                if (req_s && !hit_any_s) begin
                    state_d = victim_dirty_s ? S_WRITEBACK : S_ALLOCATE;
                end else begin
                    state_d = S_COMPARE;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp_i) begin
                    state_d = S_ALLOCATE;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_ALLOCATE: begin
                if (pmem_resp_i) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            default: state_d = S_COMPARE;
        endcase
    end

    // Output strobes decoded from the current state and inputs.
    always_comb begin
        mem_resp_o      = 1'b0;
        load_data_o     = 2'b00;
        load_tag_o      = 2'b00;
        load_valid_o    = 2'b00;
        load_dirty_o    = 2'b00;
        dirty_in_o      = 1'b0;
        load_lru_o      = 1'b0;
        lru_in_o        = 1'b0;
        datain_sel_o    = 1'b0;
        pmem_addr_sel_o = 1'b0;
        way_sel_o       = 1'b0;
        pmem_read_o     = 1'b0;
        pmem_write_o    = 1'b0;
        case (state_q)
            S_COMPARE: begin
                if (req_s && hit_any_s) begin
                    mem_resp_o = 1'b1;
                    way_sel_o  = hit_way_s;
                    load_lru_o = 1'b1;
                    lru_in_o   = ~hit_way_s;
                    if (is_write_s) begin
                        load_data_o  = hit_mask_s;
                        datain_sel_o = 1'b0;
                        load_dirty_o = hit_mask_s;
                        dirty_in_o   = 1'b1;
                    end else begin
                        load_data_o  = 2'b00;
                    end
                end else begin
                    mem_resp_o = 1'b0;
                end
            end
            S_WRITEBACK: begin
                pmem_write_o    = 1'b1;
                pmem_addr_sel_o = 1'b1;
                way_sel_o       = victim_q;
                if (pmem_resp_i) begin
                    load_dirty_o = victim_mask_s;
                    dirty_in_o   = 1'b0;
                end else begin
                    load_dirty_o = 2'b00;
                end
            end
            S_ALLOCATE: begin
                pmem_read_o     = 1'b1;
                pmem_addr_sel_o = 1'b0;
                if (pmem_resp_i) begin
                    load_data_o  = victim_mask_s;
                    load_tag_o   = victim_mask_s;
                    load_valid_o = victim_mask_s;
                    load_dirty_o = victim_mask_s;
                    datain_sel_o = 1'b1;
                    dirty_in_o   = 1'b0;
                end else begin
                    load_data_o  = 2'b00;
                end
            end
            default: begin
                mem_resp_o = 1'b0;
            end
        endcase
    end

    // Victim, missed flag and saturating counters; only S_COMPARE updates them.
    always_comb begin
        victim_d   = victim_q;
        missed_d   = missed_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_COMPARE) begin
            if (req_s && hit_any_s) begin
                missed_d = 1'b0;
                if (!missed_q && (hit_cnt_q != CNT_MAX)) begin
                    hit_cnt_d = hit_cnt_q + CNT_ONE;
                end else begin
                    hit_cnt_d = hit_cnt_q;
                end
            end else if (req_s) begin
                victim_d = lru_i;
                missed_d = 1'b1;
                if (miss_cnt_q != CNT_MAX) begin
                    miss_cnt_d = miss_cnt_q + CNT_ONE;
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end else begin
                // Idle cycle ends any abandoned miss.
                missed_d = 1'b0;
            end
        end else begin
            victim_d = victim_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            victim_q   <= 1'b0;
            missed_q   <= 1'b0;
            hit_cnt_q  <= {CNT_WIDTH{1'b0}};
            miss_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            victim_q   <= victim_d;
            missed_q   <= missed_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_l1d_cache_control.sv
// Directed bench for l1d_cache_control: expected strobe vectors are queued when
// inputs are driven and popped when the combinational outputs are sampled.
module tb_l1d_cache_control;

    localparam int CW = 4;

    typedef struct packed {
        logic       resp;
        logic [1:0] ld;
        logic [1:0] lt;
        logic [1:0] lv;
        logic [1:0] ldr;
        logic       din;
        logic       llru;
        logic       lruin;
        logic       dsel;
        logic       asel;
        logic       wsel;
        logic       pr;
        logic       pw;
    } out_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write, lru, pmem_resp;
    logic [1:0]    hit, dirty, valid;
    logic          mem_resp, dirty_in, load_lru, lru_in, datain_sel;
    logic          pmem_addr_sel, way_sel, pmem_read, pmem_write;
    logic [1:0]    load_data, load_tag, load_valid, load_dirty;
    logic [CW-1:0] hit_count, miss_count;
    out_t          obs;

    out_t  exp_q[$];
    string tag_q[$];
    int    total_cnt = 0;
    int    pass_cnt  = 0;

    always #5 clk = ~clk;

    l1d_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk), .reset_i(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .hit_i(hit), .dirty_i(dirty), .valid_i(valid), .lru_i(lru), .pmem_resp_i(pmem_resp),
        .mem_resp_o(mem_resp), .load_data_o(load_data), .load_tag_o(load_tag),
        .load_valid_o(load_valid), .load_dirty_o(load_dirty), .dirty_in_o(dirty_in),
        .load_lru_o(load_lru), .lru_in_o(lru_in), .datain_sel_o(datain_sel),
        .pmem_addr_sel_o(pmem_addr_sel), .way_sel_o(way_sel), .pmem_read_o(pmem_read),
        .pmem_write_o(pmem_write), .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    assign obs = '{resp: mem_resp, ld: load_data, lt: load_tag, lv: load_valid,
                   ldr: load_dirty, din: dirty_in, llru: load_lru, lruin: lru_in,
                   dsel: datain_sel, asel: pmem_addr_sel, wsel: way_sel,
                   pr: pmem_read, pw: pmem_write};

    function automatic logic [1:0] msk(input logic w);
        msk = w ? 2'b10 : 2'b01;
    endfunction

    function automatic out_t e_idle();
        e_idle = '0;
    endfunction

    function automatic out_t e_rhit(input logic w);
        out_t e = '0;
        e.resp = 1'b1; e.wsel = w; e.llru = 1'b1; e.lruin = ~w;
        return e;
    endfunction

    function automatic out_t e_whit(input logic w);
        out_t e = e_rhit(w);
        e.ld = msk(w); e.ldr = msk(w); e.din = 1'b1; e.dsel = 1'b0;
        return e;
    endfunction

    function automatic out_t e_wb(input logic v, input logic r);
        out_t e = '0;
        e.pw = 1'b1; e.asel = 1'b1; e.wsel = v;
        if (r) e.ldr = msk(v);
        return e;
    endfunction

    function automatic out_t e_alloc(input logic v, input logic r);
        out_t e = '0;
        e.pr = 1'b1;
        if (r) begin
            e.ld = msk(v); e.lt = msk(v); e.lv = msk(v); e.ldr = msk(v); e.dsel = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] h,
                         input logic [1:0] d, input logic [1:0] v, input logic l,
                         input logic pr);
        mem_read = rd; mem_write = wr; hit = h; dirty = d; valid = v; lru = l;
        pmem_resp = pr;
    endtask

    task automatic push(input string tag, input out_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cmp();
        out_t  e;
        string t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total_cnt++;
        assert (obs === e) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", t, obs, e);
    endtask

    task automatic chk_cnt(input string tag, input logic [CW-1:0] h, input logic [CW-1:0] m);
        total_cnt++;
        assert (hit_count === h && miss_count === m) pass_cnt++;
        else $error("FAIL %s observed hit=%0d miss=%0d expected hit=%0d miss=%0d",
                    tag, hit_count, miss_count, h, m);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(); tick();
        push("reset_out", e_idle()); cmp();
        chk_cnt("reset_cnt", 4'd0, 4'd0);
        reset = 1'b0;

        // Hits: read way1, write way0, read+write with illegal hit==11.
        drive(1'b1, 1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0);
        push("rd_hit_w1", e_rhit(1'b1)); cmp(); tick();
        chk_cnt("rd_hit_cnt", 4'd1, 4'd0);
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0);
        push("wr_hit_w0", e_whit(1'b0)); cmp(); tick();
        chk_cnt("wr_hit_cnt", 4'd2, 4'd0);
        drive(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0);
        push("rw_hit11", e_whit(1'b0)); cmp(); tick();
        chk_cnt("rw_hit11_cnt", 4'd3, 4'd0);

        // Stray pmem_resp while idle is ignored.
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        push("idle_presp", e_idle()); cmp(); tick();

        // Clean read miss, victim way1; lru moves during allocate.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
        push("clean_miss_cmp", e_idle()); cmp(); tick();
        chk_cnt("clean_miss_cnt", 4'd3, 4'd1);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push("clean_alloc_wait", e_alloc(1'b1, 1'b0)); cmp(); tick();
        end
        pmem_resp = 1'b1;
        push("clean_alloc_resp", e_alloc(1'b1, 1'b1)); cmp(); tick();
        drive(1'b1, 1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0);
        push("clean_refill_hit", e_rhit(1'b1)); cmp(); tick();
        chk_cnt("clean_done_cnt", 4'd3, 4'd1);

        // Dirty write miss, victim way0: writeback then allocate then merged write.
        drive(1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
        push("dirty_miss_cmp", e_idle()); cmp(); tick();
        chk_cnt("dirty_miss_cnt", 4'd3, 4'd2);
        lru = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("wb_wait", e_wb(1'b0, 1'b0)); cmp(); tick();
        end
        pmem_resp = 1'b1;
        push("wb_resp", e_wb(1'b0, 1'b1)); cmp(); tick();
        pmem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push("dirty_alloc_wait", e_alloc(1'b0, 1'b0)); cmp(); tick();
        end
        pmem_resp = 1'b1;
        push("dirty_alloc_resp", e_alloc(1'b0, 1'b1)); cmp(); tick();
        drive(1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0);
        push("dirty_refill_wr", e_whit(1'b0)); cmp(); tick();
        chk_cnt("dirty_done_cnt", 4'd3, 4'd2);

        // Request dropped during allocate; idle cycle clears missed.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        push("drop_miss_cmp", e_idle()); cmp(); tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        push("drop_alloc_wait", e_alloc(1'b1, 1'b0)); cmp(); tick();
        pmem_resp = 1'b1;
        push("drop_alloc_resp", e_alloc(1'b1, 1'b1)); cmp(); tick();
        pmem_resp = 1'b0;
        push("drop_idle", e_idle()); cmp(); tick();
        drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0);
        push("drop_next_hit", e_rhit(1'b0)); cmp(); tick();
        chk_cnt("drop_cnt", 4'd4, 4'd3);

        // Asynchronous reset during writeback.
        drive(1'b0, 1'b1, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        push("rst_wb_miss", e_idle()); cmp(); tick();
        push("rst_wb_active", e_wb(1'b1, 1'b0)); cmp();
        #1 reset = 1'b1;
        push("rst_wb_async", e_idle()); cmp();
        chk_cnt("rst_wb_cnt", 4'd0, 4'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        push("rst_wb_after", e_idle()); cmp(); tick();
        push("rst_wb_idle", e_idle()); cmp();

        // Hit counter saturation.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0);
        push("sat_hit", e_rhit(1'b0)); cmp();
        for (int i = 0; i < 15; i++) tick();
        chk_cnt("sat_15", 4'hF, 4'd0);
        tick(); tick();
        chk_cnt("sat_17", 4'hF, 4'd0);

        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
